viterbi_frame_ctrl: RTL and testbench

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

---
 rtl/viterbi_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller around a Viterbi decoder core.
// It loads one frame of symbols, starts the decoder, waits for it, then streams the decoded bits out.
module viterbi_frame_ctrl #(
   parameter int MAX_LEN = 255,
   parameter int TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [1:0]  s_sym,
   input  logic        s_last,
   output logic        sym_wr_en,
   output logic [7:0]  sym_wr_addr,
   output logic [1:0]  sym_wr_data,
   output logic        dec_start,
   output logic [7:0]  dec_frame_len,
   input  logic        dec_done,
   input  logic [7:0]  dec_out_len,
   output logic [7:0]  bit_rd_addr,
   input  logic        bit_rd_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_bit,
   output logic        m_last,
   output logic        busy,
   output logic        err_overflow,
   output logic        err_timeout,
   output logic [15:0] frames_done
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {LOAD, DISCARD, START, WAIT, DRAIN} state_t;

   state_t state, state_nxt;
   logic [7:0] cnt, len, idx;
   logic [WD_W-1:0] wd;
   logic s_fire, m_fire;
   logic unused_dec_out_len;

   // The drained length is always our own latched len; the decoder's view is not needed.
   assign unused_dec_out_len = ^dec_out_len;

   assign s_fire        = s_valid & s_ready;
   assign m_fire        = m_valid & m_ready;
   assign sym_wr_addr   = cnt;
   assign sym_wr_data   = s_sym;
   assign dec_frame_len = len;
   assign bit_rd_addr   = idx;
   assign m_bit         = bit_rd_data;
   assign busy          = (state != LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   // Symbol handshakes are masked while reset is held so nothing is written or accepted.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      sym_wr_en = 1'b0;
      dec_start = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      case (state)
         LOAD: begin
            s_ready   = rst_n;
            sym_wr_en = s_valid & rst_n;
            if (s_fire) begin
               if (s_last)                state_nxt = START;
               else if (cnt == LAST_IDX)  state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            s_ready = rst_n;
            if (s_fire && s_last) state_nxt = START;
         end
         START: begin
            dec_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (dec_done)            state_nxt = DRAIN;
            else if (wd == WD_LIMIT) state_nxt = LOAD;
         end
         DRAIN: begin
            m_valid = 1'b1;
            m_last  = (idx == len - 8'd1);
            if (m_ready && m_last) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // A decoder completion in the same cycle as the watchdog limit still wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= 8'd0;
         len          <= 8'd0;
         idx          <= 8'd0;
         wd           <= '0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
         frames_done  <= 16'd0;
      end else begin
         case (state)
            LOAD: begin
               if (s_fire) begin
                  cnt <= cnt + 8'd1;
                  if (s_last || cnt == LAST_IDX) len <= cnt + 8'd1;
                  if (!s_last && cnt == LAST_IDX) err_overflow <= 1'b1;
               end
            end
            START: wd <= '0;
            WAIT: begin
               if (dec_done) begin
                  idx <= 8'd0;
               end else if (wd == WD_LIMIT) begin
                  err_timeout <= 1'b1;
                  cnt         <= 8'd0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            DRAIN: begin
               if (m_fire) begin
                  idx <= idx + 8'd1;
                  if (m_last) begin
                     frames_done <= frames_done + 16'd1;
                     cnt         <= 8'd0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Randomised self-checking bench for viterbi_frame_ctrl.
// A cycle timeline built from frame-level rules predicts every output; one process compares each cycle.
module tb_viterbi_frame_ctrl;

   localparam int ML = 8;
   localparam int TO = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
   logic [1:0]  s_sym = 2'd0;
   logic        sym_wr_en;
   logic [7:0]  sym_wr_addr;
   logic [1:0]  sym_wr_data;
   logic        dec_start, dec_done = 1'b0;
   logic [7:0]  dec_frame_len, dec_out_len = 8'd0;
   logic [7:0]  bit_rd_addr;
   logic        bit_rd_data;
   logic        m_valid, m_ready = 1'b0, m_bit, m_last;
   logic        busy, err_overflow, err_timeout;
   logic [15:0] frames_done;

   logic dec_mem [256];

   viterbi_frame_ctrl #(.MAX_LEN(ML), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym), .s_last(s_last),
      .sym_wr_en(sym_wr_en), .sym_wr_addr(sym_wr_addr), .sym_wr_data(sym_wr_data),
      .dec_start(dec_start), .dec_frame_len(dec_frame_len), .dec_done(dec_done), .dec_out_len(dec_out_len),
      .bit_rd_addr(bit_rd_addr), .bit_rd_data(bit_rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_bit(m_bit), .m_last(m_last),
      .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout), .frames_done(frames_done)
   );

   assign bit_rd_data = dec_mem[bit_rd_addr];

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int frames_model = 0;
   bit ovf_model = 1'b0;
   bit tmo_model = 1'b0;

   bit chk_en = 1'b0;
   bit e_ready, e_busy, e_wr, e_start, e_lenchk, e_mv, e_last, e_bit, e_ovf, e_tmo;
   int e_waddr, e_wdata, e_len, e_raddr, e_frames;

   int hs_cnt = 0, start_cnt = 0, wr_cnt = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expectIdle();
      e_ready  = rst_n;
      e_busy   = 1'b0;
      e_wr     = 1'b0;
      e_start  = 1'b0;
      e_lenchk = 1'b0;
      e_mv     = 1'b0;
      e_last   = 1'b0;
      e_frames = frames_model;
      e_ovf    = ovf_model;
      e_tmo    = tmo_model;
   endtask

   task automatic expectBusy(input int len);
      expectIdle();
      e_ready  = 1'b0;
      e_busy   = 1'b1;
      e_lenchk = 1'b1;
      e_len    = len;
   endtask

   task automatic driveNoise();
      s_valid  = 1'($urandom);
      s_sym    = 2'($urandom);
      s_last   = 1'($urandom);
      m_ready  = 1'($urandom);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("s_ready", 32'(s_ready), 32'(e_ready));
         checkOutput("busy", 32'(busy), 32'(e_busy));
         checkOutput("sym_wr_en", 32'(sym_wr_en), 32'(e_wr));
         if (e_wr) begin
            checkOutput("sym_wr_addr", 32'(sym_wr_addr), e_waddr);
            checkOutput("sym_wr_data", 32'(sym_wr_data), e_wdata);
         end
         checkOutput("dec_start", 32'(dec_start), 32'(e_start));
         if (e_lenchk) checkOutput("dec_frame_len", 32'(dec_frame_len), e_len);
         checkOutput("m_valid", 32'(m_valid), 32'(e_mv));
         checkOutput("m_last", 32'(m_last), 32'(e_last));
         if (e_mv) begin
            checkOutput("m_bit", 32'(m_bit), 32'(e_bit));
            checkOutput("bit_rd_addr", 32'(bit_rd_addr), e_raddr);
         end
         checkOutput("err_overflow", 32'(err_overflow), 32'(e_ovf));
         checkOutput("err_timeout", 32'(err_timeout), 32'(e_tmo));
         checkOutput("frames_done", 32'(frames_done), e_frames);
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) hs_cnt++;
         if (dec_start) start_cnt++;
         if (sym_wr_en) wr_cnt++;
      end
   end

   task automatic doReset();
      rst_n = 1'b0;
      frames_model = 0;
      ovf_model = 1'b0;
      tmo_model = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      expectIdle();
      #1;
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_frames_done", 32'(frames_done), 32'd0);
      checkOutput("rst_err_overflow", 32'(err_overflow), 32'd0);
      checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
      repeat (2) begin
         nextCycle();
         expectIdle();
      end
      rst_n = 1'b1;
      expectIdle();
   endtask

   // One frame of n symbols; hang keeps dec_done low; abort_at pulses reset when that bit index is reached.
   task automatic applyStimulus(input int n, input bit hang, input int delay, input int abort_at);
      int sent = 0;
      int len;
      int idx = 0;
      int guard = 0;
      len = (n < ML) ? n : ML;
      while (sent < n) begin
         nextCycle();
         expectIdle();
         s_valid  = ($urandom_range(0, 3) != 0);
         s_sym    = 2'($urandom);
         s_last   = (sent == n - 1);
         m_ready  = 1'($urandom);
         dec_done = 1'($urandom);
         e_busy   = (sent >= ML);
         e_wr     = s_valid && (sent < ML);
         e_waddr  = sent;
         e_wdata  = int'(s_sym);
         if (s_valid) begin
            if (sent == ML - 1 && !s_last) ovf_model = 1'b1;
            sent++;
         end
      end
      nextCycle();
      expectBusy(len);
      e_start = 1'b1;
      driveNoise();
      dec_done = 1'($urandom);
      dec_out_len = 8'($urandom);
      for (int i = 0; i < 256; i++) dec_mem[i] = 1'($urandom);
      for (int w = 0; w < TO; w++) begin
         nextCycle();
         expectBusy(len);
         driveNoise();
         dec_done = !hang && (w >= delay);
         if (dec_done) break;
         if (w == TO - 1) tmo_model = 1'b1;
      end
      if (hang) return;
      forever begin
         nextCycle();
         guard++;
         if (idx == abort_at) begin
            doReset();
            return;
         end
         expectBusy(len);
         driveNoise();
         e_mv    = 1'b1;
         e_raddr = idx;
         e_bit   = dec_mem[idx];
         e_last  = (idx == len - 1);
         m_ready = (guard > 32) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (m_ready) begin
            if (idx == len - 1) begin
               frames_model++;
               break;
            end
            idx++;
         end
      end
   endtask

   task automatic idleCycles(input int k);
      repeat (k) begin
         nextCycle();
         expectIdle();
         s_valid = 1'b0;
         m_ready = 1'($urandom);
         dec_done = 1'($urandom);
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) dec_mem[i] = 1'b0;
      #2;
      rst_n = 1'b0;
      expectIdle();
      chk_en = 1'b1;
      repeat (2) nextCycle();
      rst_n = 1'b1;
      expectIdle();
      #1;
      checkOutput("init_s_ready", 32'(s_ready), 32'd1);
      checkOutput("init_busy", 32'(busy), 32'd0);
      checkOutput("init_frames_done", 32'(frames_done), 32'd0);

      applyStimulus(8, 1'b0, 19, -1);
      idleCycles(2);
      checkOutput("f8_frames_done", 32'(frames_done), 32'd1);
      checkOutput("f8_handshakes", hs_cnt, 32'd8);
      checkOutput("f8_starts", start_cnt, 32'd1);
      checkOutput("f8_writes", wr_cnt, 32'd8);
      checkOutput("f8_err_overflow", 32'(err_overflow), 32'd0);

      applyStimulus(4, 1'b0, 3, -1);
      idleCycles(1);
      checkOutput("f4_handshakes", hs_cnt, 32'd12);

      applyStimulus(10, 1'b0, 5, -1);
      idleCycles(1);
      checkOutput("ovf_flag", 32'(err_overflow), 32'd1);
      checkOutput("ovf_writes", wr_cnt, 32'd20);
      checkOutput("ovf_handshakes", hs_cnt, 32'd20);
      checkOutput("ovf_frames_done", 32'(frames_done), 32'd3);

      applyStimulus(3, 1'b1, 0, -1);
      idleCycles(1);
      checkOutput("tmo_flag", 32'(err_timeout), 32'd1);
      checkOutput("tmo_frames_done", 32'(frames_done), 32'd3);
      checkOutput("tmo_handshakes", hs_cnt, 32'd20);

      applyStimulus(1, 1'b0, 0, -1);
      applyStimulus(3, 1'b0, 1, -1);
      idleCycles(1);
      checkOutput("b2b_frames_done", 32'(frames_done), 32'd5);
      checkOutput("b2b_starts", start_cnt, 32'd6);
      checkOutput("b2b_handshakes", hs_cnt, 32'd24);

      applyStimulus(6, 1'b0, 2, 3);
      idleCycles(1);
      checkOutput("abort_handshakes", hs_cnt, 32'd27);
      checkOutput("abort_writes", wr_cnt, 32'd33);
      checkOutput("abort_frames_done", 32'(frames_done), 32'd0);

      for (int f = 0; f < 40; f++) begin
         applyStimulus($urandom_range(1, 12), ($urandom_range(0, 7) == 0), $urandom_range(0, TO - 1), -1);
         idleCycles($urandom_range(0, 2));
      end
      idleCycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
